// File: rtl/enc_ctrl_if.sv
// Control/status bundle between the turbo-encoder controller and its datapath.
// The slave side is the controller; the master side drives start requests.
interface enc_ctrl_if #(
  parameter int unsigned CNT_W = 14
) ();
  logic             data_valid;
  logic [CNT_W-1:0] blk_len;
  logic             enable;
  logic             trellis_enable;
  logic             switch;
  logic             clr;
  logic             trl_clr;
  logic             mod_clr;
  logic [2:0]       current_state;
  logic [CNT_W-1:0] bit_cnt;
  logic             blk_done;
  logic             len_err;

  modport master (
    output data_valid, blk_len,
    input  enable, trellis_enable, switch, clr, trl_clr, mod_clr,
    input  current_state, bit_cnt, blk_done, len_err
  );

  modport slave (
    input  data_valid, blk_len,
    output enable, trellis_enable, switch, clr, trl_clr, mod_clr,
    output current_state, bit_cnt, blk_done, len_err
  );
endinterface

// File: rtl/enc_ctrl.sv
// Turbo-encoder block sequencer: encode phase, trellis tail phase, and one queued
// start request so consecutive blocks run without an idle gap. All outputs registered.
module enc_ctrl #(
  parameter int unsigned CNT_W    = 14,
  parameter int unsigned TAIL_LEN = 3,
  parameter int unsigned MIN_LEN  = 40,
  parameter int unsigned MAX_LEN  = 6144
) (
  input logic       clk,
  input logic       reset,
  enc_ctrl_if.slave bus
);

  if (MIN_LEN < 2) begin : g_bad_min_len
    $error("enc_ctrl: MIN_LEN must be at least 2");
  end
  if (TAIL_LEN < 1 || TAIL_LEN > 7) begin : g_bad_tail_len
    $error("enc_ctrl: TAIL_LEN must be in 1..7");
  end
  if (MAX_LEN >= (64'd1 << CNT_W) || MIN_LEN > MAX_LEN) begin : g_bad_max_len
    $error("enc_ctrl: MAX_LEN must fit in CNT_W bits and be >= MIN_LEN");
  end

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StEncode = 3'd1;
  localparam logic [2:0] StTail   = 3'd2;

  localparam logic [CNT_W-1:0] MinLen   = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MaxLen   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] TailLast = CNT_W'(TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] One      = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two      = CNT_W'(2);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] pend_len_q, pend_len_d;
  logic             pend_q, pend_d;
  logic             enable_q, enable_d;
  logic             trellis_q, trellis_d;
  logic             switch_q, switch_d;
  logic             clr_q, clr_d;
  logic             trl_clr_q, trl_clr_d;
  logic             mod_clr_q, mod_clr_d;
  logic             blk_done_q, blk_done_d;
  logic             len_err_q, len_err_d;

  logic len_legal;
  logic tail_last;
  logic can_queue;

  assign len_legal = (bus.blk_len >= MinLen) && (bus.blk_len <= MaxLen);
  assign tail_last = (state_q == StTail) && (cnt_q == TailLast);
  // The final tail cycle consumes requests directly instead of queueing them.
  assign can_queue = ((state_q == StEncode) || ((state_q == StTail) && !tail_last)) && !pend_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    pend_len_d = pend_len_q;
    pend_d     = pend_q;
    enable_d   = enable_q;
    trellis_d  = trellis_q;
    switch_d   = switch_q;
    clr_d      = clr_q;
    trl_clr_d  = 1'b0;
    mod_clr_d  = 1'b0;
    blk_done_d = 1'b0;
    len_err_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.data_valid) begin
          if (len_legal) begin
            len_d    = bus.blk_len;
            cnt_d    = '0;
            enable_d = 1'b1;
            clr_d    = 1'b0;
            state_d  = StEncode;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      StEncode: begin
        if (cnt_q == len_q - One) begin
          enable_d  = 1'b0;
          trellis_d = 1'b0;
          switch_d  = 1'b1;
          cnt_d     = '0;
          state_d   = StTail;
        end else begin
          cnt_d = cnt_q + One;
          if (cnt_q == len_q - Two) trellis_d = 1'b1;
        end
      end
      StTail: begin
        if (tail_last) begin
          blk_done_d = 1'b1;
          trl_clr_d  = 1'b1;
          switch_d   = 1'b0;
          cnt_d      = '0;
          if (pend_q || (bus.data_valid && len_legal)) begin
            len_d     = pend_q ? pend_len_q : bus.blk_len;
            pend_d    = 1'b0;
            enable_d  = 1'b1;
            mod_clr_d = 1'b1;
            state_d   = StEncode;
          end else begin
            len_err_d = bus.data_valid;
            clr_d     = 1'b1;
            state_d   = StIdle;
          end
        end else begin
          cnt_d = cnt_q + One;
        end
      end
      default: begin
        state_d   = StIdle;
        cnt_d     = '0;
        pend_d    = 1'b0;
        enable_d  = 1'b0;
        trellis_d = 1'b0;
        switch_d  = 1'b0;
        clr_d     = 1'b1;
      end
    endcase

    if (can_queue && bus.data_valid) begin
      if (len_legal) begin
        pend_d     = 1'b1;
        pend_len_d = bus.blk_len;
      end else begin
        len_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      pend_len_q <= '0;
      pend_q     <= 1'b0;
      enable_q   <= 1'b0;
      trellis_q  <= 1'b0;
      switch_q   <= 1'b0;
      clr_q      <= 1'b1;
      trl_clr_q  <= 1'b0;
      mod_clr_q  <= 1'b0;
      blk_done_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      pend_len_q <= pend_len_d;
      pend_q     <= pend_d;
      enable_q   <= enable_d;
      trellis_q  <= trellis_d;
      switch_q   <= switch_d;
      clr_q      <= clr_d;
      trl_clr_q  <= trl_clr_d;
      mod_clr_q  <= mod_clr_d;
      blk_done_q <= blk_done_d;
      len_err_q  <= len_err_d;
    end
  end

  assign bus.current_state  = state_q;
  assign bus.bit_cnt        = cnt_q;
  assign bus.enable         = enable_q;
  assign bus.trellis_enable = trellis_q;
  assign bus.switch         = switch_q;
  assign bus.clr            = clr_q;
  assign bus.trl_clr        = trl_clr_q;
  assign bus.mod_clr        = mod_clr_q;
  assign bus.blk_done       = blk_done_q;
  assign bus.len_err        = len_err_q;

endmodule
